// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, FSM encoding and lookup tables for the AES-128
// round controller (aes_round_ctrl). Optional abort input: AES_CTRL_ABORT_EN.
package aes_pkg;

    localparam int unsigned AES_NR  = 10;
    localparam int unsigned BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

    // Entry 0 is unused; rounds index 1..10.
    localparam logic [7:0] RCON_TBL [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX_TBL [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constant for a round index; out-of-range indices yield zero.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        return (idx <= 4'd10) ? RCON_TBL[idx] : 8'h00;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_add_round_key.sv
// aes_add_round_key: XOR of the block with the round key.
module aes_add_round_key
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] data_i,
    input  logic [BLOCK_W-1:0] rkey_i,
    output logic [BLOCK_W-1:0] data_o
);

    assign data_o = data_i ^ rkey_i;

endmodule

// File: rtl/aes_key_step.sv
// aes_key_step: one combinational AES-128 key expansion step
// (current round key + Rcon -> next round key).
module aes_key_step
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] rkey_i,
    input  logic [7:0]         rcon_i,
    output logic [BLOCK_W-1:0] rkey_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rkey_i;

    // SubWord(RotWord(w3)) with the round constant folded into the top byte.
    assign t = {SBOX_TBL[w3[23:16]] ^ rcon_i, SBOX_TBL[w3[15:8]],
                SBOX_TBL[w3[7:0]], SBOX_TBL[w3[31:24]]};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rkey_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_mix_columns.sv
// aes_mix_columns: per-column multiply by the fixed MixColumns matrix.
module aes_mix_columns
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] data_i,
    output logic [BLOCK_W-1:0] data_o
);

    logic [7:0] a0, a1, a2, a3;

    // Each column is mixed independently; 3*a is expressed as xtime(a)^a.
    always_comb begin
        data_o = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = data_i[127-32*c -: 8];
            a1 = data_i[119-32*c -: 8];
            a2 = data_i[111-32*c -: 8];
            a3 = data_i[103-32*c -: 8];
            data_o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            data_o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            data_o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            data_o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

endmodule

// File: rtl/aes_shift_rows.sv
// aes_shift_rows: cyclic left shift of state row r by r byte positions.
// Byte k of the block sits at row k%4, column k/4.
module aes_shift_rows
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] data_i,
    output logic [BLOCK_W-1:0] data_o
);

    // Pure byte permutation.
    always_comb begin
        data_o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                data_o[BLOCK_W-1-8*(r+4*c) -: 8] = data_i[BLOCK_W-1-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    end

endmodule

// File: rtl/aes_sub_bytes.sv
// aes_sub_bytes: S-box substitution applied to each byte of the block.
module aes_sub_bytes
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] data_i,
    output logic [BLOCK_W-1:0] data_o
);

    // Independent table lookup per byte.
    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < BLOCK_W / 8; i++) begin
            data_o[BLOCK_W-1-8*i -: 8] = SBOX_TBL[data_i[BLOCK_W-1-8*i -: 8]];
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryptor, one round per clock.
// Optional macro AES_CTRL_ABORT_EN adds an 'abort' input that cancels a job.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic               clk,
    input  logic               rstn,
`ifdef AES_CTRL_ABORT_EN
    input  logic               abort,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] plain_text,
    input  logic [BLOCK_W-1:0] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] cipher_text,
    output logic               busy
);

    localparam logic [3:0] LAST_MIX_ROUND = 4'(NR - 1);

    aes_state_e         fsm_q, fsm_d;
    logic [3:0]         round_q, round_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [BLOCK_W-1:0] rkey_q, rkey_d;
    logic               in_ready_q, out_valid_q, busy_q;
    logic [BLOCK_W-1:0] cipher_q;

    logic [BLOCK_W-1:0] sb_out, sr_out, mc_out, ark_in, ark_out, next_rkey;
    logic [7:0]         rcon_cur;
    logic               abort_hit;

`ifdef AES_CTRL_ABORT_EN
    assign abort_hit = abort && (fsm_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign rcon_cur = rcon(round_q);

    aes_sub_bytes u_sub_bytes (
        .data_i (blk_q),
        .data_o (sb_out)
    );

    aes_shift_rows u_shift_rows (
        .data_i (sb_out),
        .data_o (sr_out)
    );

    aes_mix_columns u_mix_columns (
        .data_i (sr_out),
        .data_o (mc_out)
    );

    // The final round bypasses MixColumns.
    assign ark_in = (fsm_q == FINAL) ? sr_out : mc_out;

    aes_add_round_key u_add_round_key (
        .data_i (ark_in),
        .rkey_i (next_rkey),
        .data_o (ark_out)
    );

    aes_key_step u_key_step (
        .rkey_i (rkey_q),
        .rcon_i (rcon_cur),
        .rkey_o (next_rkey)
    );

    // Next-state, round counter and datapath register selection.
    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        blk_d   = blk_q;
        rkey_d  = rkey_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    blk_d   = plain_text ^ key;
                    rkey_d  = key;
                    round_d = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                blk_d   = ark_out;
                rkey_d  = next_rkey;
                round_d = round_q + 4'd1;
                if (round_q == LAST_MIX_ROUND) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                blk_d  = ark_out;
                rkey_d = next_rkey;
                fsm_d  = DONE;
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    fsm_d   = IDLE;
                    round_d = '0;
                    blk_d   = '0;
                    rkey_d  = '0;
                end
            end
            default: begin
                fsm_d   = IDLE;
                round_d = '0;
                blk_d   = '0;
                rkey_d  = '0;
            end
        endcase
        if (abort_hit) begin
            fsm_d   = IDLE;
            round_d = '0;
            blk_d   = '0;
            rkey_d  = '0;
        end
    end

    // State registers plus registered handshake outputs. out_valid and
    // cipher_text are loaded from the DONE state one edge after entering it,
    // which yields the 11-edge accept-to-result latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_q       <= IDLE;
            round_q     <= '0;
            blk_q       <= '0;
            rkey_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cipher_q    <= '0;
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            blk_q       <= blk_d;
            rkey_q      <= rkey_d;
            in_ready_q  <= (fsm_d == IDLE);
            busy_q      <= (fsm_d != IDLE);
            out_valid_q <= (fsm_q == DONE) && (fsm_d == DONE);
            cipher_q    <= ((fsm_q == DONE) && (fsm_d == DONE)) ? blk_q : '0;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign cipher_text = cipher_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed + randomized checks of aes_round_ctrl against
// known-answer vectors and a byte-level AES-128 reference model.
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plain_text;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] cipher_text;
    logic         busy;
`ifdef AES_CTRL_ABORT_EN
    logic         abort;
`endif

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;
    logic [7:0]  sb [256];

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_round_ctrl #(.NR(10)) dut (
        .clk         (clk),
        .rstn        (rstn),
`ifdef AES_CTRL_ABORT_EN
        .abort       (abort),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .plain_text  (plain_text),
        .key         (key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .cipher_text (cipher_text),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] rk [16];
        logic [7:0] tmp [4];
        logic [7:0] mrow [4];
        logic [7:0] rc;
        logic [127:0] res;
        mrow = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 16; i++) begin
            s[i]  = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
            rk[i] = k[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            tmp[0] = sb[rk[13]] ^ rc;
            tmp[1] = sb[rk[14]];
            tmp[2] = sb[rk[15]];
            tmp[3] = sb[rk[12]];
            for (int j = 0; j < 4; j++) rk[j] = rk[j] ^ tmp[j];
            for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
            rc = gmul(rc, 8'h02);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r+4*c] = sb[s[r+4*((c+r)%4)]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rnd == 10) begin
                        s[r+4*c] = t[r+4*c];
                    end else begin
                        s[r+4*c] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            s[r+4*c] = s[r+4*c] ^ gmul(mrow[(j-r+4)%4], t[j+4*c]);
                    end
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents the job for one accept edge.
    task automatic start_job(input string tag, input logic [127:0] pt, input logic [127:0] k);
        int unsigned n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready_before_accept"}, 128'(in_ready), 128'(1));
        in_valid   = 1'b1;
        plain_text = pt;
        key        = k;
        tick();
        in_valid   = 1'b0;
        plain_text = rand128();
        key        = rand128();
    endtask

    // Counts edges after the accept edge until out_valid; optionally pokes
    // in_valid/key while the core sits in rounds 3..7.
    task automatic wait_result(input bit disturb, output int unsigned lat, output bit quiet_ok);
        lat = 0;
        quiet_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
            if (out_valid !== 1'b1 &&
                (cipher_text !== '0 || in_ready !== 1'b0 || busy !== 1'b1)) quiet_ok = 1'b0;
            if (disturb && lat >= 2 && lat <= 6) begin
                in_valid   = (lat % 2 == 0);
                key        = rand128();
                plain_text = rand128();
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_job(input string tag, input int unsigned stall);
        logic [127:0] held;
        bit           stable;
        held   = cipher_text;
        stable = 1'b1;
        for (int i = 0; i < int'(stall); i++) begin
            tick();
            if (out_valid !== 1'b1 || cipher_text !== held || in_ready !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
        end
        if (stall != 0) check({tag, "_backpressure_stable"}, 128'(stable), 128'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_post_valid"},  128'(out_valid), 128'(0));
        check({tag, "_post_ct"},     cipher_text,     128'(0));
        check({tag, "_post_ready"},  128'(in_ready),  128'(1));
        check({tag, "_post_busy"},   128'(busy),      128'(0));
    endtask

    task automatic do_job(input string tag, input logic [127:0] pt, input logic [127:0] k,
                          input logic [127:0] exp, input bit disturb, input int unsigned stall);
        int unsigned lat;
        bit          quiet_ok;
        start_job(tag, pt, k);
        wait_result(disturb, lat, quiet_ok);
        check({tag, "_latency"},      128'(lat),      128'(11));
        check({tag, "_quiet_rounds"}, 128'(quiet_ok), 128'(1));
        check({tag, "_ct"},           cipher_text,    exp);
        check({tag, "_no_overlap"},   128'(in_ready), 128'(0));
        finish_job(tag, stall);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] rpt, rk;
        bit           seen;
        build_sbox();
        rstn       = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        plain_text = '0;
        key        = '0;
`ifdef AES_CTRL_ABORT_EN
        abort      = 1'b0;
`endif

        // Reset state.
        #12;
        check("rst_in_ready",  128'(in_ready),  128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy",      128'(busy),      128'(0));
        check("rst_ct",        cipher_text,     128'(0));
        tick();
        rstn = 1'b1;
        check("rel_in_ready_before_edge", 128'(in_ready), 128'(0));
        tick();
        check("rel_in_ready_first_edge",  128'(in_ready), 128'(1));

        // Known-answer vectors, second one under 20 cycles of backpressure.
        do_job("kat1", PT1, K1, CT1, 1'b0, 0);
        do_job("kat2_bp", PT2, K2, CT2, 1'b0, 20);

        // New inputs offered during rounds 3-7 must be ignored.
        do_job("kat1_ignore_inputs", PT1, K1, CT1, 1'b1, 1);

        // Reset pulse during round 5 discards the job.
        start_job("rst_mid", PT1, K1);
        repeat (4) tick();
        rstn = 1'b0;
        #2;
        check("rst_mid_out_valid", 128'(out_valid), 128'(0));
        check("rst_mid_busy",      128'(busy),      128'(0));
        check("rst_mid_in_ready",  128'(in_ready),  128'(0));
        check("rst_mid_ct",        cipher_text,     128'(0));
        tick();
        rstn = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("rst_mid_no_output", 128'(seen), 128'(0));
        do_job("kat2_after_rst", PT2, K2, CT2, 1'b0, 0);

        // Random jobs against the reference model.
        for (int n = 0; n < 6; n++) begin
            rpt = rand128();
            rk  = rand128();
            do_job($sformatf("rand%0d", n), rpt, rk, ref_encrypt(rpt, rk), 1'b0,
                   $urandom_range(0, 5));
        end

`ifdef AES_CTRL_ABORT_EN
        // Abort at round 4.
        start_job("abort_r4", PT1, K1);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_r4_in_ready", 128'(in_ready),  128'(1));
        check("abort_r4_busy",     128'(busy),      128'(0));
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("abort_r4_no_output", 128'(seen), 128'(0));
        do_job("kat2_after_abort", PT2, K2, CT2, 1'b0, 0);

        // Abort in IDLE has no effect on an accepted job.
        abort = 1'b1;
        start_job("abort_idle", PT2, K2);
        abort = 1'b0;
        check("abort_idle_busy", 128'(busy), 128'(1));
        repeat (12) tick();
        check("abort_idle_ct", cipher_text, CT2);

        // Abort beats out_ready in DONE.
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        check("abort_done_out_valid", 128'(out_valid), 128'(0));
        check("abort_done_in_ready",  128'(in_ready),  128'(1));
        do_job("kat1_after_abort", PT1, K1, CT1, 1'b0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
